// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage with operand select, ALU, data SRAM request
// and a 32-step restoring divider for DIV/DIVU that stalls the pipeline.
// Ports: clk, rst (sync, active-low), stall vector, id_to_ex_bus in;
// ex_to_mem_bus, ex_to_rf_bus, hilo_bus, stallreq_for_ex, data_sram_* out.
module ex_stage #(
    parameter int ID_TO_EX_WD  = 159,
    parameter int EX_TO_MEM_WD = 76,
    parameter int EX_TO_RF_WD  = 38,
    parameter int STALL_WD     = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus,
    output logic [64:0]             hilo_bus,
    output logic                    stallreq_for_ex,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [11:0] alu_op;
        logic [2:0]  sel_src1;
        logic [3:0]  sel_src2;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        sel_rf_res;
        logic [31:0] data1;
        logic [31:0] data2;
    } id_ex_t;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_st_t;

    id_ex_t id_ex;

    always_ff @(posedge clk) begin
        if (!rst)
            id_ex <= '0;
        else if (stall[2] && !stall[3])
            id_ex <= '0;
        else if (!stall[2])
            id_ex <= id_ex_t'(id_to_ex_bus);
    end

    logic [31:0] src1, src2, ex_result;
    logic [4:0]  shamt;

    always_comb begin
        src1 = ({32{id_ex.sel_src1[0]}} & id_ex.data1)
             | ({32{id_ex.sel_src1[1]}} & id_ex.pc)
             | ({32{id_ex.sel_src1[2]}} & {27'b0, id_ex.inst[10:6]});
        src2 = ({32{id_ex.sel_src2[0]}} & id_ex.data2)
             | ({32{id_ex.sel_src2[1]}}
                & {{16{id_ex.inst[15]}}, id_ex.inst[15:0]})
             | ({32{id_ex.sel_src2[2]}} & 32'd8)
             | ({32{id_ex.sel_src2[3]}} & {16'b0, id_ex.inst[15:0]});
    end

    assign shamt = src1[4:0];

    always_comb begin
        ex_result = '0;
        unique case (1'b1)
            id_ex.alu_op[11]: ex_result = src1 + src2;
            id_ex.alu_op[10]: ex_result = src1 - src2;
            id_ex.alu_op[9]:  ex_result = {31'b0, $signed(src1) < $signed(src2)};
            id_ex.alu_op[8]:  ex_result = {31'b0, src1 < src2};
            id_ex.alu_op[7]:  ex_result = src1 & src2;
            id_ex.alu_op[6]:  ex_result = ~(src1 | src2);
            id_ex.alu_op[5]:  ex_result = src1 | src2;
            id_ex.alu_op[4]:  ex_result = src1 ^ src2;
            id_ex.alu_op[3]:  ex_result = src2 << shamt;
            id_ex.alu_op[2]:  ex_result = src2 >> shamt;
            id_ex.alu_op[1]:  ex_result = $signed(src2) >>> shamt;
            id_ex.alu_op[0]:  ex_result = {src2[15:0], 16'h0};
            default:          ex_result = '0;
        endcase
    end

    assign ex_to_rf_bus  = {id_ex.rf_we, id_ex.rf_waddr, ex_result};
    assign ex_to_mem_bus = {id_ex.pc, id_ex.ram_en, id_ex.ram_wen,
                            id_ex.sel_rf_res, id_ex.rf_we,
                            id_ex.rf_waddr, ex_result};

    assign data_sram_en    = id_ex.ram_en;
    assign data_sram_wen   = id_ex.ram_wen;
    assign data_sram_addr  = ex_result;
    assign data_sram_wdata = id_ex.data2;

    logic is_div, is_sdiv;
    logic a_neg, b_neg;
    logic [31:0] a_mag, b_mag;

    assign is_div  = (id_ex.inst[31:26] == 6'h0)
                   && (id_ex.inst[5:1] == 5'b01101);
    assign is_sdiv = is_div && !id_ex.inst[0];
    assign a_neg   = is_sdiv && id_ex.data1[31];
    assign b_neg   = is_sdiv && id_ex.data2[31];
    assign a_mag   = a_neg ? -id_ex.data1 : id_ex.data1;
    assign b_mag   = b_neg ? -id_ex.data2 : id_ex.data2;

    div_st_t     state, state_nx;
    logic [31:0] quo, rem, dvs;
    logic [4:0]  cnt;
    logic        neg_q, neg_r;
    logic [32:0] trial;
    logic        fits;

    // Trial can exceed 32 bits; it is always below 2*dvs so the
    // subtracted remainder still fits in 32 bits.
    assign trial = {rem, quo[31]};
    assign fits  = trial >= {1'b0, dvs};

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (is_div) state_nx = BUSY;
            BUSY:    if (cnt == 5'd31) state_nx = DONE;
            DONE:    if (!stall[2]) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            quo   <= '0;
            rem   <= '0;
            dvs   <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == IDLE && is_div) begin
            quo   <= a_mag;
            rem   <= '0;
            dvs   <= b_mag;
            cnt   <= '0;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
        end else if (state == BUSY) begin
            rem <= fits ? 32'(trial - {1'b0, dvs}) : trial[31:0];
            quo <= {quo[30:0], fits};
            cnt <= cnt + 5'd1;
        end
    end

    always_comb begin
        stallreq_for_ex = 1'b0;
        hilo_bus        = '0;
        unique case (state)
            IDLE: stallreq_for_ex = is_div;
            BUSY: stallreq_for_ex = 1'b1;
            DONE: hilo_bus = {1'b1,
                              neg_r ? -rem : rem,
                              neg_q ? -quo : quo};
            default: ;
        endcase
    end

    logic unused_ok;
    assign unused_ok = ^{stall[STALL_WD-1:4], stall[1:0],
                         id_ex.inst[25:16]};

endmodule
